seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment driver; successor to the fixed 4-digit song-name display.
//  Holds a character buffer written by the player control FSM and scans digits at a divided rate.
//  Decodes 5-bit character codes (hex digits and a letter subset) to segment patterns.
//  Registered outputs drive the board's shared segment bus and the one-hot digit-enable lines.
// PARAMETERS
//  N_DIGITS    8       digits scanned (2..8)
//  SCAN_DIV    100000  clk cycles per digit slot (>=2); 100 MHz -> 1 kHz digit rate
//  MSG_LEN     16      message buffer depth; used only with SEG_SCROLL_EN (>= N_DIGITS)
//  SCROLL_DIV  250     full scan frames per scroll step; used only with SEG_SCROLL_EN
// PORTS
//  clk        in   1                     system clock; single clock domain
//  reset_n    in   1                     asynchronous active-low reset
//  wr_en      in   1                     write strobe, one char per cycle
//  wr_addr    in   $clog2(MSG_LEN|N_DIG) buffer index
//  wr_data    in   5                     character code (seg_pkg)
//  dp_mask    in   N_DIGITS              decimal point per physical digit, bit i -> digit i
//  blank      in   1                     1 = all digits off
//  scroll_en  in   1                     1 = advance scroll window; ignored without SEG_SCROLL_EN
//  seg        out  8                     {dp,a,b,c,d,e,f,g}, active-high
//  an         out  N_DIGITS              one-hot digit enable, active-high
// BEHAVIOUR
//  - Reset (async assert, sync release): seg=0, an=0, digit index=0, prescaler=0, buffer all BLANK (0x10), scroll offset=0.
//  - Prescaler counts 0..SCAN_DIV-1; tick on terminal count; index increments on tick, wraps N_DIGITS-1 -> 0.
//  - After reset release: the first clock edge loads an=1<<0 and seg=decode(digit 0).
//  - Every clock: an <= blank ? 0 : (1<<idx); seg <= blank ? 0 : {dp_mask[idx], rom(char(idx))}.
//    seg and an always change on the same edge, never skewed.
//  - Write: edge t updates buffer. If the digit is active, the new pattern is on seg after edge t+1 (latency 2 from wr_en).
//  - wr_addr >= buffer depth: write dropped, no side effects.
//  - Tick and write to the active digit in the same cycle: the write lands; the next digit is shown.
//  - blank 1->0: the correct digit is shown after the next edge; scanning continues while blanked.
//  - Unassigned codes (0x1B..0x1F) decode as blank (segments 0); dp is still honoured.
//  - Reset mid-scan or mid-write: immediate return to reset state; any write in flight is lost.
// CONFIGURATION
//  SEG_SCROLL_EN defined:
//   - Buffer depth = MSG_LEN.
//   - Digit i shows buf[(offset+i) mod MSG_LEN].
//   - Offset increments after every SCROLL_DIV completed frames (frame = wrap of idx to 0) while scroll_en=1.
//   - Offset wraps MSG_LEN-1 -> 0.
//   - scroll_en=0 holds the offset and clears the frame counter.
//  SEG_SCROLL_EN undefined:
//   - Buffer depth = N_DIGITS; digit i shows buf[i].
//   - scroll_en ignored; MSG_LEN and SCROLL_DIV unused.
// STRUCTURE
//  seg_pkg:
//   - CHAR_W=5.
//   - Char codes 0x00-0x0F hex 0-F, 0x10 BLANK, 0x11 r, 0x12 t, 0x13 y, 0x14 n, 0x15 o, 0x16 P, 0x17 L, 0x18 H, 0x19 U, 0x1A dash.
//   - SEG_* 7-bit pattern constants.
//  Sub-module seg_char_rom: combinational 5->7 decode, reusable by other display blocks.
//  Top holds the prescaler, index, buffer, scroll logic and output registers.
// TESTING (bench uses SCAN_DIV=4, N_DIGITS=4, MSG_LEN=8, SCROLL_DIV=2)
//  1. Reset with buffer untouched -> seg=0, an=0; after release, an cycles 0001,0010,0100,1000,0001 every 4 clk with seg=0.
//  2. Write codes 0x05,0x12,0x0A,0x11 ("5tAr") to addr 0..3 -> when an=0001, seg=8'b0101_1011; when an=0010, seg=8'b0000_1111.
//  3. Write addr 0 = 0x08 while an=0001 -> seg=8'b0111_1111 two edges after wr_en; tick on the same cycle -> the digit-1 pattern appears.
//  4. dp_mask=4'b0100, blank pulse of 3 cycles -> seg[7]=1 only when an=0100; an=0 for exactly 3 edges.
//  5. wr_addr=7 without SEG_SCROLL_EN -> buffer unchanged; invalid code 0x1F -> seg[6:0]=0.
//  6. SEG_SCROLL_EN, buffer 0..7 = 0..7, scroll_en=1 -> digit0 shows 1 after 2 frames; reaches 7, then 0.
//     Drop scroll_en -> the window freezes.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared character codes and seven-segment patterns for the display blocks.
// Segment pattern bit order is {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

  localparam int CHAR_W = 5;
  localparam int SEG_W  = 7;

  typedef enum logic [CHAR_W-1:0] {
    CH_0     = 5'h00, CH_1 = 5'h01, CH_2 = 5'h02, CH_3 = 5'h03,
    CH_4     = 5'h04, CH_5 = 5'h05, CH_6 = 5'h06, CH_7 = 5'h07,
    CH_8     = 5'h08, CH_9 = 5'h09, CH_A = 5'h0A, CH_B = 5'h0B,
    CH_C     = 5'h0C, CH_D = 5'h0D, CH_E = 5'h0E, CH_F = 5'h0F,
    CH_BLANK = 5'h10,
    CH_R     = 5'h11, CH_T = 5'h12, CH_Y = 5'h13, CH_N = 5'h14,
    CH_O     = 5'h15, CH_P = 5'h16, CH_L = 5'h17, CH_H = 5'h18,
    CH_U     = 5'h19, CH_DASH = 5'h1A
  } char_e;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A    = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B    = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C    = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D    = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E    = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F    = 7'b1000111;
  localparam logic [SEG_W-1:0] SEG_R    = 7'b0000101;
  localparam logic [SEG_W-1:0] SEG_T    = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_Y    = 7'b0111011;
  localparam logic [SEG_W-1:0] SEG_N    = 7'b0010101;
  localparam logic [SEG_W-1:0] SEG_O    = 7'b0011101;
  localparam logic [SEG_W-1:0] SEG_P    = 7'b1100111;
  localparam logic [SEG_W-1:0] SEG_L    = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_H    = 7'b0110111;
  localparam logic [SEG_W-1:0] SEG_U    = 7'b0111110;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg_char_rom.sv
// Combinational character-code to segment-pattern decode.
// Codes without a glyph (BLANK and 0x1B..0x1F) light nothing.
module seg_char_rom
  import seg_pkg::*;
(
  input  logic [CHAR_W-1:0] i_char,
  output logic [SEG_W-1:0]  o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_char)
      CH_0:    o_seg = SEG_0;
      CH_1:    o_seg = SEG_1;
      CH_2:    o_seg = SEG_2;
      CH_3:    o_seg = SEG_3;
      CH_4:    o_seg = SEG_4;
      CH_5:    o_seg = SEG_5;
      CH_6:    o_seg = SEG_6;
      CH_7:    o_seg = SEG_7;
      CH_8:    o_seg = SEG_8;
      CH_9:    o_seg = SEG_9;
      CH_A:    o_seg = SEG_A;
      CH_B:    o_seg = SEG_B;
      CH_C:    o_seg = SEG_C;
      CH_D:    o_seg = SEG_D;
      CH_E:    o_seg = SEG_E;
      CH_F:    o_seg = SEG_F;
      CH_R:    o_seg = SEG_R;
      CH_T:    o_seg = SEG_T;
      CH_Y:    o_seg = SEG_Y;
      CH_N:    o_seg = SEG_N;
      CH_O:    o_seg = SEG_O;
      CH_P:    o_seg = SEG_P;
      CH_L:    o_seg = SEG_L;
      CH_H:    o_seg = SEG_H;
      CH_U:    o_seg = SEG_U;
      CH_DASH: o_seg = SEG_DASH;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with character buffer and digit scan.
// Define SEG_SCROLL_EN for a MSG_LEN-deep message buffer with a scrolling window.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter  int N_DIGITS   = 8,
  parameter  int SCAN_DIV   = 100000,
  parameter  int MSG_LEN    = 16,
  parameter  int SCROLL_DIV = 250,
  // Address port is sized for the larger (message) buffer in both builds.
  localparam int ADDR_W     = $clog2(MSG_LEN)
)(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CHAR_W-1:0]   wr_data,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                blank,
  input  logic                scroll_en,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
`ifdef SEG_SCROLL_EN
  localparam int DEPTH = MSG_LEN;
`else
  localparam int DEPTH = N_DIGITS;
`endif
  localparam int BUF_W = $clog2(DEPTH);

  logic [PRE_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [CHAR_W-1:0]   r_buf [DEPTH];
  logic [7:0]          r_seg;
  logic [N_DIGITS-1:0] r_an;

  logic                w_tick;
  logic                w_wr_ok;
  logic [BUF_W-1:0]    w_wr_idx;
  logic [BUF_W-1:0]    w_rd_idx;
  logic [CHAR_W-1:0]   w_char;
  logic [SEG_W-1:0]    w_pat;

  assign w_tick   = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_wr_idx = wr_addr[BUF_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= CH_BLANK;
      end
    end else if (w_wr_ok) begin
      r_buf[w_wr_idx] <= wr_data;
    end
  end

`ifdef SEG_SCROLL_EN
  localparam int FRM_W = $clog2(SCROLL_DIV + 1);

  logic [FRM_W-1:0] r_frame;
  logic [BUF_W-1:0] r_off;
  logic             w_frame;
  logic [BUF_W:0]   w_sum;

  // A frame completes when the scan wraps from the last digit back to digit 0.
  assign w_frame = w_tick && (r_idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
      r_off   <= '0;
    end else if (!scroll_en) begin
      r_frame <= '0;
    end else if (w_frame) begin
      if (r_frame == FRM_W'(SCROLL_DIV - 1)) begin
        r_frame <= '0;
        r_off   <= (r_off == BUF_W'(MSG_LEN - 1)) ? '0 : r_off + 1'b1;
      end else begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  assign w_sum    = {1'b0, r_off} + (BUF_W + 1)'(r_idx);
  assign w_rd_idx = (w_sum >= (BUF_W + 1)'(MSG_LEN)) ?
                    BUF_W'(w_sum - (BUF_W + 1)'(MSG_LEN)) : w_sum[BUF_W-1:0];
`else
  logic w_unused_scroll;

  assign w_rd_idx        = BUF_W'(r_idx);
  assign w_unused_scroll = scroll_en ^ (SCROLL_DIV == 0);
`endif

  assign w_char = r_buf[w_rd_idx];

  seg_char_rom u_rom (
    .i_char (w_char),
    .o_seg  (w_pat)
  );

  // seg and an share one register stage so they can never be skewed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= '0;
      r_an  <= '0;
    end else if (blank) begin
      r_seg <= '0;
      r_an  <= '0;
    end else begin
      r_seg <= {dp_mask[r_idx], w_pat};
      r_an  <= N_DIGITS'(1) << r_idx;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 4 clk per slot).
// Scroll expectations switch with SEG_SCROLL_EN.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int ML = 8;
  localparam int SC = 2;
  localparam int AW = $clog2(ML);

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [4:0]    wr_data   = '0;
  logic [N-1:0]  dp_mask   = '0;
  logic          blank     = 1'b0;
  logic          scroll_en = 1'b0;
  logic [7:0]    seg;
  logic [N-1:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .N_DIGITS   (N),
    .SCAN_DIV   (SD),
    .MSG_LEN    (ML),
    .SCROLL_DIV (SC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dp_mask   (dp_mask),
    .blank     (blank),
    .scroll_en (scroll_en),
    .seg       (seg),
    .an        (an)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // cyc counts rising edges since the last reset release; sampling is 1 time unit after.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic wr(input int addr, input logic [4:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic disp(input string tag, input int k, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    step_to(k);
    chk({tag, "_an"}, {4'b0, an}, {4'b0, exp_an});
    chk({tag, "_seg"}, seg, exp_seg);
  endtask

  initial begin
    // 1. reset state and blank scan
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", seg, 8'h00);
    chk("rst_an", {4'b0, an}, 8'h00);
    reset_n = 1'b1;
    cyc     = 0;
    disp("scan0", 1, 4'b0001, 8'h00);
    disp("scan0_hold", 4, 4'b0001, 8'h00);
    disp("scan1", 5, 4'b0010, 8'h00);
    disp("scan2", 9, 4'b0100, 8'h00);
    disp("scan3", 13, 4'b1000, 8'h00);
    disp("scan_wrap", 17, 4'b0001, 8'h00);

    // 2. "5tAr"
    wr(0, 5'h05);
    wr(1, 5'h12);
    wr(2, 5'h0A);
    wr(3, 5'h11);
    disp("d0_5", 33, 4'b0001, 8'h5B);
    disp("d1_t", 37, 4'b0010, 8'h0F);
    disp("d2_A", 41, 4'b0100, 8'h77);
    disp("d3_r", 45, 4'b1000, 8'h05);

    // 3. write to the active digit, then a write coinciding with the tick
    step_to(48);
    wr(0, 5'h08);
    disp("wr_lat1", 49, 4'b0001, 8'h5B);
    disp("wr_lat2", 50, 4'b0001, 8'h7F);
    step_to(51);
    wr(0, 5'h16);
    disp("tickwr_old", 52, 4'b0001, 8'h7F);
    disp("tickwr_next", 53, 4'b0010, 8'h0F);
    disp("tickwr_land", 65, 4'b0001, 8'h67);

    // 4. decimal point and blank pulse
    dp_mask = 4'b0100;
    disp("dp_d1", 69, 4'b0010, 8'h0F);
    disp("dp_d2", 73, 4'b0100, 8'hF7);
    disp("dp_d3", 77, 4'b1000, 8'h05);
    disp("blank_pre", 78, 4'b1000, 8'h05);
    blank = 1'b1;
    disp("blank_e1", 79, 4'b0000, 8'h00);
    disp("blank_e2", 80, 4'b0000, 8'h00);
    disp("blank_e3", 81, 4'b0000, 8'h00);
    blank = 1'b0;
    disp("blank_post", 82, 4'b0001, 8'h67);

    // 5. out-of-range address and unassigned codes
    wr(7, 5'h00);
    disp("oor_d0", 97, 4'b0001, 8'h67);
    disp("oor_d1", 101, 4'b0010, 8'h0F);
    disp("oor_d2", 105, 4'b0100, 8'hF7);
    disp("oor_d3", 109, 4'b1000, 8'h05);
    wr(2, 5'h1F);
    disp("inv1F_dp", 121, 4'b0100, 8'h80);
    wr(3, 5'h1B);
    disp("inv1B", 125, 4'b1000, 8'h00);

    // reset in the middle of a write
    wr_en   = 1'b1;
    wr_addr = AW'(0);
    wr_data = 5'h08;
    reset_n = 1'b0;
    #1;
    chk("midrst_seg", seg, 8'h00);
    chk("midrst_an", {4'b0, an}, 8'h00);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    dp_mask = 4'b0000;
    reset_n = 1'b1;
    cyc     = 0;
    disp("postrst_d0", 1, 4'b0001, 8'h00);
    disp("postrst_d2", 9, 4'b0100, 8'h00);

    // 6. scroll window (or scroll_en ignored)
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    for (int i = 0; i < 8; i++) wr(i, 5'(i));
    step_to(16);
    scroll_en = 1'b1;
`ifdef SEG_SCROLL_EN
    disp("scr_off0", 33, 4'b0001, 8'h7E);
    disp("scr_off1", 49, 4'b0001, 8'h30);
    disp("scr_off7", 241, 4'b0001, 8'h70);
    disp("scr_off7_d1", 245, 4'b0010, 8'h7E);
    disp("scr_wrap", 273, 4'b0001, 8'h7E);
    scroll_en = 1'b0;
    disp("scr_wrap_d1", 277, 4'b0010, 8'h30);
    disp("scr_freeze1", 305, 4'b0001, 8'h7E);
    disp("scr_freeze2", 337, 4'b0001, 8'h7E);
`else
    disp("noscr_d0a", 33, 4'b0001, 8'h7E);
    disp("noscr_d0b", 49, 4'b0001, 8'h7E);
    disp("noscr_d0c", 241, 4'b0001, 8'h7E);
    disp("noscr_d1", 245, 4'b0010, 8'h30);
    disp("noscr_d3", 253, 4'b1000, 8'h79);
    scroll_en = 1'b0;
    disp("noscr_d2", 281, 4'b0100, 8'h6D);
    disp("noscr_d0d", 305, 4'b0001, 8'h7E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
